// File: rtl/hpdcache_wbuf_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hpdcache_wbuf_timer                                        |
// | Description : Per-entry ageing timers for the write-buffer directory.    |
// |               Each entry is FREE, OPEN or PEND. An OPEN entry ages on    |
// |               tick_i. It becomes PEND when its age reaches the threshold |
// |               or when flush_all_i is high. PEND entries are offered to   |
// |               the data path through a round-robin valid/ready port.      |
// | Ports       : clk_i, rst_i (sync, active-high)                           |
// |               tick_i, cfg_threshold_i    : ageing timebase / threshold   |
// |               open_i/open_idx_i          : allocate an entry             |
// |               write_i/write_idx_i        : write merged into an entry    |
// |               flush_all_i                : force all OPEN entries to PEND|
// |               send_valid_o/send_idx_o/send_ready_i : send handshake      |
// |               busy_o                     : some entry is not FREE        |
// | Config      : HPDCACHE_WBUF_TIMER_RESET_ON_WRITE_EN - when defined, a    |
// |               write to an OPEN entry clears its age counter.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hpdcache_wbuf_timer #(
   parameter int unsigned DIR_ENTRIES   = 16,
   parameter int unsigned TIMECNT_WIDTH = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           tick_i,
   input  logic [TIMECNT_WIDTH-1:0]       cfg_threshold_i,
   input  logic                           open_i,
   input  logic [$clog2(DIR_ENTRIES)-1:0] open_idx_i,
   input  logic                           write_i,
   input  logic [$clog2(DIR_ENTRIES)-1:0] write_idx_i,
   input  logic                           flush_all_i,
   output logic                           send_valid_o,
   output logic [$clog2(DIR_ENTRIES)-1:0] send_idx_o,
   input  logic                           send_ready_i,
   output logic                           busy_o
);

   localparam int unsigned IDX_W = $clog2(DIR_ENTRIES);

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_OPEN = 2'd1,
      ST_PEND = 2'd2
   } entry_state_e;

   entry_state_e             state_q  [DIR_ENTRIES];
   entry_state_e             state_d  [DIR_ENTRIES];
   logic [TIMECNT_WIDTH-1:0] cnt_q    [DIR_ENTRIES];
   logic [TIMECNT_WIDTH-1:0] cnt_d    [DIR_ENTRIES];
   // An entry spends its first cycle after allocation without ageing or
   // threshold evaluation, so ageing is measured from the cycle after open.
   logic [DIR_ENTRIES-1:0]   settle_q, settle_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   // Once a request is offered, its index is frozen until the handshake so
   // newly pending entries cannot steal an outstanding offer.
   logic                     lock_q, lock_d;
   logic [IDX_W-1:0]         lock_idx_q, lock_idx_d;

   logic [DIR_ENTRIES-1:0]   pend_vec;
   logic [DIR_ENTRIES-1:0]   used_vec;
   logic [IDX_W-1:0]         arb_idx;
   logic                     hs;

`ifndef HPDCACHE_WBUF_TIMER_RESET_ON_WRITE_EN
   logic unused_write;
   assign unused_write = ^{write_i, write_idx_i};
`endif

   always_comb begin
      for (int unsigned i = 0; i < DIR_ENTRIES; i++) begin
         pend_vec[i] = (state_q[i] == ST_PEND);
         used_vec[i] = (state_q[i] != ST_FREE);
      end
   end

   // Round-robin search starting just after the last granted index.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      found   = 1'b0;
      cand    = '0;
      arb_idx = '0;
      for (int unsigned k = 1; k <= DIR_ENTRIES; k++) begin
         cand = rr_ptr_q + IDX_W'(k);
         if (!found && pend_vec[cand]) begin
            found   = 1'b1;
            arb_idx = cand;
         end
      end
   end

   assign send_valid_o = |pend_vec;
   assign send_idx_o   = lock_q ? lock_idx_q : arb_idx;
   assign busy_o       = |used_vec;
   assign hs           = send_valid_o && send_ready_i;

   always_comb begin
      logic granted;
      logic opening;
      granted  = 1'b0;
      opening  = 1'b0;
      settle_d = '0;
      for (int unsigned i = 0; i < DIR_ENTRIES; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         granted    = hs && (send_idx_o == IDX_W'(i));
         opening    = open_i && (open_idx_i == IDX_W'(i));
         unique case (state_q[i])
            ST_OPEN: begin
               if (!settle_q[i]) begin
                  if (tick_i && (cnt_q[i] != '1)) begin
                     cnt_d[i] = cnt_q[i] + TIMECNT_WIDTH'(1);
                  end
                  if (cnt_q[i] >= cfg_threshold_i) begin
                     state_d[i] = ST_PEND;
                  end
               end
`ifdef HPDCACHE_WBUF_TIMER_RESET_ON_WRITE_EN
               if (write_i && (write_idx_i == IDX_W'(i))) begin
                  cnt_d[i] = '0;
               end
`endif
               if (flush_all_i) begin
                  state_d[i] = ST_PEND;
               end
            end
            ST_PEND: begin
               if (granted) begin
                  state_d[i] = ST_FREE;
               end
            end
            default: begin
            end
         endcase
         // A re-open racing with the handshake of the same entry wins.
         if (opening && ((state_q[i] == ST_FREE) || granted)) begin
            state_d[i]  = ST_OPEN;
            cnt_d[i]    = '0;
            settle_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      if (hs) begin
         lock_d   = 1'b0;
         rr_ptr_d = send_idx_o;
      end else if (send_valid_o) begin
         lock_d     = 1'b1;
         lock_idx_d = send_idx_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DIR_ENTRIES; i++) begin
            state_q[i] <= ST_FREE;
            cnt_q[i]   <= '0;
         end
         settle_q   <= '0;
         rr_ptr_q   <= IDX_W'(DIR_ENTRIES - 1);
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DIR_ENTRIES; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         settle_q   <= settle_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i && open_i) begin
         assert ((state_q[open_idx_i] == ST_FREE) || (hs && (send_idx_o == open_idx_i)))
            else $error("open_i to busy entry %0d ignored", open_idx_i);
      end
   end
`endif

endmodule
`default_nettype wire
